// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit synchronous BCD up/down counter with validated load and wrap flags
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Carry,
  output logic                  Borrow,
  output logic                  LoadErr
);
  // all_nine[i] / all_zero[i]: every digit below i is 9 / 0, i.e. digit i gets a carry / borrow
  logic [DIGITS:0]   all_nine;
  logic [DIGITS:0]   all_zero;
  logic [DIGITS-1:0] bad_nib;
  logic              load_ok;
  assign all_nine[0] = 1'b1;
  assign all_zero[0] = 1'b1;
  assign load_ok     = Load & ~|bad_nib;
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] q;
    logic [3:0] q_next;
    logic       step;
    assign Count[4*d+:4] = q;
    assign all_nine[d+1] = all_nine[d] & (q == 4'd9);
    assign all_zero[d+1] = all_zero[d] & (q == 4'd0);
    assign bad_nib[d]    = LoadVal[4*d+:4] > 4'd9;
    assign step          = En & (Up ? all_nine[d] : all_zero[d]);
    always_comb q_next = Up ? ((q == 4'd9) ? 4'd0 : q + 4'd1) : ((q == 4'd0) ? 4'd9 : q - 4'd1);
    always_ff @(posedge Clk)
      if (Clear) q <= 4'd0;
      else if (Load) q <= load_ok ? LoadVal[4*d+:4] : q;
      else if (step) q <= q_next;
  end
  always_ff @(posedge Clk)
    if (Clear) begin
      Carry   <= 1'b0;
      Borrow  <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      Carry   <= ~Load & En & Up & all_nine[DIGITS];
      Borrow  <= ~Load & En & ~Up & all_zero[DIGITS];
      LoadErr <= Load & ~load_ok;
    end
endmodule
